// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizes for the single-port RAM burst controller.
package ram_ctrl_pkg;

  localparam int RAM_WIDTH   = 8;
  localparam int RAM_ADDR    = 6;
  localparam int BURST_LEN_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_ISSUE = 3'd2,
    RD_CAPT  = 3'd3,
    RD_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/ram_burst_cnt.sv
// Burst address / remaining-beat counter used by the RAM burst master.
module ram_burst_cnt #(
  parameter int ADDR  = 6,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             wrap,
  input  logic [ADDR-1:0]  load_addr,
  input  logic [LEN_W-1:0] load_len,
  output logic [ADDR-1:0]  cur_addr,
  output logic             last
);

  logic [LEN_W-1:0] beats_left;

  assign last = (beats_left == '0);

  // Load a new burst, or advance one beat; the beat count saturates at zero
  // and the address either wraps modulo depth or parks at the top address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr   <= '0;
      beats_left <= '0;
    end else if (load) begin
      cur_addr   <= load_addr;
      beats_left <= load_len;
    end else if (step) begin
      if (wrap || (cur_addr != '1)) begin
        cur_addr <= cur_addr + 1'b1;
      end
      if (beats_left != '0) begin
        beats_left <= beats_left - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_burst_master.sv
// Burst command front end for the single-port synchronous RAM: owns the
// write-enable, address and data pins and returns read beats with backpressure.
module ram_burst_master
  import ram_ctrl_pkg::*;
#(
  parameter int WIDTH = RAM_WIDTH,
  parameter int ADDR  = RAM_ADDR,
  parameter int LEN_W = BURST_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_wr,
  input  logic [ADDR-1:0]  cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wd_valid,
  output logic             wd_ready,
  input  logic [WIDTH-1:0] wd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_last,
  output logic             done,
  output logic [WIDTH-1:0] ram_data,
  output logic [ADDR-1:0]  ram_addr,
  output logic             ram_wnr,
  input  logic [WIDTH-1:0] ram_q
);

  state_t          state;
  logic            cnt_load;
  logic            cnt_step;
  logic            cnt_last;
  logic [ADDR-1:0] cur_addr;
  logic            wr_beat;
  logic            rd_hs;

  // The write strobe comes straight from the state register, so an
  // asynchronous reset drops it in the same instant.
  assign wr_beat   = (state == WR) && wd_valid;
  assign rd_hs     = (state == RD_RESP) && rd_ready;
  assign cnt_load  = (state == IDLE) && cmd_valid;
  assign cnt_step  = wr_beat || (rd_hs && !cnt_last);

  assign cmd_ready = (state == IDLE);
  assign wd_ready  = (state == WR);
  assign ram_wnr   = wr_beat;
  assign ram_addr  = cur_addr;
  assign ram_data  = (state == WR) ? wd_data : '0;

  ram_burst_cnt #(
    .ADDR  (ADDR),
    .LEN_W (LEN_W)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cnt_load),
    .step      (cnt_step),
    .wrap      (1'b1),
    .load_addr (cmd_addr),
    .load_len  (cmd_len),
    .cur_addr  (cur_addr),
    .last      (cnt_last)
  );

  // Burst sequencing plus the registered read-response and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state <= cmd_wr ? WR : RD_ISSUE;
          end
        end
        WR: begin
          if (wd_valid && cnt_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        RD_ISSUE: begin
          state <= RD_CAPT;
        end
        RD_CAPT: begin
          rd_data  <= ram_q;
          rd_valid <= 1'b1;
          rd_last  <= cnt_last;
          state    <= RD_RESP;
        end
        RD_RESP: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (cnt_last) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= RD_ISSUE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
